// File: rtl/spram_arb.sv
// Two-port arbiter in front of a single-port 32-bit SPRAM: round-robin between
// ports A and B, with a bounded lock so one port can hold the memory for RMW.
module spram_arb #(
    parameter int AW       = 15,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_lock,
    input  logic          a_we,
    input  logic [AW+1:0] a_addr,
    input  logic [3:0]    a_bmsk,
    input  logic [31:0]   a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,

    input  logic          b_req,
    input  logic          b_lock,
    input  logic          b_we,
    input  logic [AW+1:0] b_addr,
    input  logic [3:0]    b_bmsk,
    input  logic [31:0]   b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [31:0]   b_rdata,

    output logic [AW-1:0] m_ai,
    output logic          m_we,
    output logic [3:0]    m_bmsk,
    output logic [31:0]   m_vi,
    input  logic [31:0]   m_vo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t      state;
    logic        last;      // 0 = A was granted last, 1 = B
    logic [7:0]  lcnt;
    logic [8:0]  lcnt_inc;
    logic        lock_ok;
    logic        unused_addr_lsbs;

    assign lcnt_inc = {1'b0, lcnt} + 9'd1;
    assign lock_ok  = lcnt_inc < 9'(MAX_LOCK);

    // Byte lane inside the word is selected by the mask, not the address.
    assign unused_addr_lsbs = ^{a_addr[1:0], b_addr[1:0]};

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (state == LOCK_A && a_req) begin
                a_gnt = 1'b1;
            end else if (state == LOCK_B && b_req) begin
                b_gnt = 1'b1;
            end else if (a_req && b_req) begin
                a_gnt = last;
                b_gnt = ~last;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        m_ai   = '0;
        m_we   = 1'b0;
        m_bmsk = '0;
        m_vi   = '0;
        if (a_gnt) begin
            m_ai   = a_addr[AW+1:2];
            m_we   = a_we;
            m_bmsk = a_bmsk;
            m_vi   = a_wdata;
        end else if (b_gnt) begin
            m_ai   = b_addr[AW+1:2];
            m_we   = b_we;
            m_bmsk = b_bmsk;
            m_vi   = b_wdata;
        end
    end

    assign a_rdata = m_vo;
    assign b_rdata = m_vo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            lcnt     <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (a_gnt) begin
                last <= 1'b0;
                if (a_lock && lock_ok) begin
                    state <= LOCK_A;
                    lcnt  <= lcnt_inc[7:0];
                end else begin
                    state <= IDLE;
                    lcnt  <= '0;
                end
            end else if (b_gnt) begin
                last <= 1'b1;
                if (b_lock && lock_ok) begin
                    state <= LOCK_B;
                    lcnt  <= lcnt_inc[7:0];
                end else begin
                    state <= IDLE;
                    lcnt  <= '0;
                end
            end else begin
                state <= IDLE;
                lcnt  <= '0;
            end
        end
    end

endmodule

// File: doc/spram_arb.md
Name: spram_arb

Overview:
- Two-requester arbiter in front of the 32K x 32-bit single-port SPRAM (mb32 slave side: word address, we, byte mask, write data, read data).
- Port A is the eJ32 core data path. Port B is the secondary master (instruction fetch / loader / trace).
- Issues at most one memory access per clock, using round-robin priority plus a bounded lock for atomic read-modify-write.
- Returns read data one cycle after grant, with a per-port valid strobe.

Parameters:
- AW, 15, word-address width to memory; byte address width is AW+2.
- MAX_LOCK, 8, max consecutive locked grants to one port before a forced release; range 1..255.

Ports:
- clk  in  1  system clock; SPRAM shares it.
- rst_n  in  1  asynchronous reset, active low.
- a_req / b_req  in  1  access request; held until granted.
- a_lock / b_lock  in  1  keep ownership on following cycles (RMW).
- a_we / b_we  in  1  1=write, 0=read.
- a_addr / b_addr  in  AW+2  byte address; word = addr[AW+1:2]; addr[1:0] ignored.
- a_bmsk / b_bmsk  in  4  byte write enables; bit n = byte n (bit 3 = [31:24]).
- a_wdata / b_wdata  in  32  write data.
- a_gnt / b_gnt  out  1  combinational; access accepted this cycle.
- a_rvalid / b_rvalid  out  1  registered; read data valid this cycle.
- a_rdata / b_rdata  out  32  read data; equals m_vo, meaningful only with rvalid.
- m_ai  out  AW  memory word address.
- m_we  out  1  memory write enable.
- m_bmsk  out  4  memory byte mask.
- m_vi  out  32  memory write data.
- m_vo  in  32  memory read data, valid the cycle after the address.

Behaviour:
- State: {IDLE, LOCK_A, LOCK_B}.
  - last: 1 bit, last granted port; 0=A, 1=B.
  - lcnt: 8-bit locked-grant counter.
- Reset (async, rst_n=0) → state=IDLE, last=B, lcnt=0, a_rvalid=b_rvalid=0.
  - a_gnt and b_gnt are forced to 0 while rst_n=0.
- IDLE arbitration (combinational):
  - Only one req → grant it.
  - Both → grant the port != last.
  - Neither → no grant.
- LOCK_X:
  - If X_req=1, grant X regardless of the other port.
  - If X_req=0, arbitrate as IDLE.
- Memory mux:
  - Granted port's addr/we/bmsk/wdata drive m_*.
  - No grant → m_we=0, m_bmsk=0, m_ai=0, m_vi=0.
  - m_we is never 1 without a grant.
- Read return:
  - X_rvalid <= X_gnt & ~X_we at every edge.
  - X_rdata = m_vo continuously.
  - Read latency exactly 1 cycle; a write produces no rvalid.
- Registered update on each edge with a grant to X:
  - last <= X.
  - If X_lock=1 and (lcnt+1) < MAX_LOCK → state <= LOCK_X, lcnt <= lcnt+1.
  - Otherwise → state <= IDLE, lcnt <= 0.
  - Result: at most MAX_LOCK consecutive grants under lock, after which the normal round-robin decides.
- No grant on an edge → state <= IDLE, lcnt <= 0.
- Back-to-back:
  - A port may be granted on consecutive cycles.
  - Read followed by write to the same word: the read returns the old data.
  - Write followed by read: the read returns the new data.
- Simultaneous requests when lock expires: the other port wins (last=X).
- A lone requester keeps winning every cycle.
- Reset mid-access: a pending rvalid is dropped. The memory array contents are not touched by reset.

Test Plan:
- Single read: b_req=1, b_we=0, b_addr=0x00104 after memory word 0x41 = 0xDEADBEEF → b_gnt same cycle, m_ai=0x41; next cycle b_rvalid=1, b_rdata=0xDEADBEEF; a_rvalid stays 0.
- Byte write: a_we=1, a_addr=0x00008, a_bmsk=4'b0100, a_wdata=0x00AB0000 over word 0x11223344, then read of word 2 → rdata=0x11AB3344.
- Contention round-robin: a_req=b_req=1 held with reads for 4 cycles from reset → grants A, B, A, B; each rvalid one cycle after its own grant.
- Lock cap: MAX_LOCK=3, a_lock=1, a_req=b_req=1 continuously → A,A,A,B,A,A,A,B…; lock deasserted after the 2nd A → next grant B.
- Idle/no-write safety: a_req=b_req=0 for 5 cycles → m_we=0, m_bmsk=0, no rvalid, memory unchanged on readback.
- Async reset: rst_n pulled low between clock edges during a read grant → gnt outputs 0 immediately, rvalid 0 at the next edge; after release the first contention grant goes to A.
